// File: rtl/alt_compr_pkg.sv
// Shared definitions for the alternating compressor controller:
// controller states, timer width and the compressor rotate-mask builder.
package alt_compr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        LOCKOUT = 2'd2
    } state_e;

    // Width of every internal timer.
    localparam int CNT_W    = 8;
    // Largest supported number of compressors.
    localparam int MAX_COMP = 8;

    // Sets k consecutive bits starting at bit 'lead', wrapping modulo n.
    function automatic logic [MAX_COMP-1:0] rot_mask(input int lead, input int k, input int n);
        logic [MAX_COMP-1:0] mask;
        logic [2:0]          idx;
        mask = '0;
        for (int i = 0; i < MAX_COMP; i++) begin
            if (i < k) begin
                idx       = 3'((lead + i) % n);
                mask[idx] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/alt_compr_timer.sv
// Clear/enable counter that saturates at LIMIT. tc_o is high while the
// count is LIMIT-1 or more, i.e. the cycle being counted is the LIMIT-th.
module alt_compr_timer
    import alt_compr_pkg::*;
#(
    parameter int LIMIT = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over enable; hold once LIMIT is reached.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/alt_compr_n.sv
// Alternating lead/lag compressor controller for N_COMP compressors.
// PB stages compressors on one at a time from the lead, PA stops them and
// rotates the lead, PMB forces a lockout that only PA can clear.
// Optional feature macro ALT_COMPR_MINRUN_EN: PA is ignored until the
// controller has spent MIN_RUN cycles in RUN.
module alt_compr_n
    import alt_compr_pkg::*;
#(
    parameter int N_COMP    = 3,
    parameter int STAGE_DLY = 8,
    parameter int MIN_RUN   = 4
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      PA,
    input  logic                      PB,
    input  logic                      PMB,
    output logic [N_COMP-1:0]         C,
    output logic [$clog2(N_COMP)-1:0] Lead,
    output logic                      Fault
);

    localparam int LW = $clog2(N_COMP);
    localparam int KW = $clog2(N_COMP + 1);

    if (N_COMP < 2 || N_COMP > MAX_COMP || STAGE_DLY < 1 || STAGE_DLY > 255 ||
        MIN_RUN < 1 || MIN_RUN > 255) begin : g_param_check
        $error("alt_compr_n: parameter out of legal range");
    end

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [LW-1:0]     lead_q, lead_d;
    logic [N_COMP-1:0] c_q, c_d;
    logic              fault_q, fault_d;

    logic pa_ok;
    logic stage_en;
    logic stage_tc;
    logic stage_hit;

`ifdef ALT_COMPR_MINRUN_EN
    logic run_tc;

    // Cycles spent in RUN; held at zero outside RUN so it restarts on entry.
    alt_compr_timer #(.LIMIT(MIN_RUN)) u_run_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clr_i (state_q != RUN),
        .en_i  (state_q == RUN),
        .tc_o  (run_tc)
    );

    assign pa_ok = PA & run_tc;
`else
    assign pa_ok = PA;
`endif

    // Staging advances only on a RUN cycle that stays in RUN with demand and spare compressors.
    assign stage_en  = (state_q == RUN) & ~PMB & ~pa_ok & PB & (k_q < KW'(N_COMP));
    assign stage_hit = stage_en & stage_tc;

    alt_compr_timer #(.LIMIT(STAGE_DLY)) u_stage_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clr_i (~stage_en | stage_tc),
        .en_i  (stage_en),
        .tc_o  (stage_tc)
    );

    // Next state, active count and lead; outputs are derived from the next state.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lead_d  = lead_q;
        unique case (state_q)
            IDLE: begin
                if (PMB) begin
                    state_d = LOCKOUT;
                end else if (PB) begin
                    state_d = RUN;
                    k_d     = KW'(1);
                end
            end
            RUN: begin
                if (PMB) begin
                    state_d = LOCKOUT;
                    k_d     = '0;
                end else if (pa_ok) begin
                    state_d = IDLE;
                    k_d     = '0;
                    lead_d  = (lead_q == LW'(N_COMP - 1)) ? '0 : lead_q + 1'b1;
                end else if (stage_hit) begin
                    k_d = k_q + 1'b1;
                end
            end
            LOCKOUT: begin
                if (!PMB && PA) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
        fault_d = (state_d == LOCKOUT);
        c_d     = (state_d == RUN) ? N_COMP'(rot_mask(int'(lead_d), int'(k_d), N_COMP)) : '0;
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            lead_q  <= '0;
            c_q     <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lead_q  <= lead_d;
            c_q     <= c_d;
            fault_q <= fault_d;
        end
    end

    assign C     = c_q;
    assign Lead  = lead_q;
    assign Fault = fault_q;

endmodule

// File: tb/tb_alt_compr_n.sv
// Self-checking bench for alt_compr_n (N_COMP=3, STAGE_DLY=8, MIN_RUN=4).
// A cycle-level model of the controller rules runs beside the DUT and is
// compared on every falling edge; directed sequences pin the model with
// literal expectations, then randomized inputs and resets follow.
module tb_alt_compr_n;

    localparam int N_COMP    = 3;
    localparam int STAGE_DLY = 8;
    localparam int MIN_RUN   = 4;
`ifdef ALT_COMPR_MINRUN_EN
    localparam int PA_HOLD   = MIN_RUN;
    localparam bit MINRUN_ON = 1'b1;
`else
    localparam int PA_HOLD   = 1;
    localparam bit MINRUN_ON = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LOCK = 2;

    logic       Clk;
    logic       Reset;
    logic       PA, PB, PMB;
    logic [2:0] C;
    logic [1:0] Lead;
    logic       Fault;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    alt_compr_n #(
        .N_COMP    (N_COMP),
        .STAGE_DLY (STAGE_DLY),
        .MIN_RUN   (MIN_RUN)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .PA    (PA),
        .PB    (PB),
        .PMB   (PMB),
        .C     (C),
        .Lead  (Lead),
        .Fault (Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int mode;   // M_IDLE / M_RUN / M_LOCK
        int k;      // compressors running
        int lead;   // lead compressor index
        int stage;  // consecutive staging PB cycles
        int run;    // RUN cycles completed (saturating)
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.mode = M_IDLE; r.k = 0; r.lead = 0; r.stage = 0; r.run = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, bit pa, bit pb, bit pmb);
        mdl_t r = s;
        bit   honour;
        case (s.mode)
            M_IDLE: begin
                if (pmb) r.mode = M_LOCK;
                else if (pb) begin
                    r.mode = M_RUN; r.k = 1; r.stage = 0; r.run = 0;
                end
            end
            M_RUN: begin
                honour = pa && (!MINRUN_ON || (s.run + 1 >= MIN_RUN));
                if (pmb) begin
                    r.mode = M_LOCK; r.k = 0; r.stage = 0;
                end else if (honour) begin
                    r.mode = M_IDLE; r.k = 0; r.stage = 0;
                    r.lead = (s.lead + 1) % N_COMP;
                end else begin
                    r.run = (s.run + 1 > MIN_RUN) ? MIN_RUN : s.run + 1;
                    if (pb && s.k < N_COMP) begin
                        r.stage = s.stage + 1;
                        if (r.stage == STAGE_DLY) begin
                            r.k = s.k + 1; r.stage = 0;
                        end
                    end else begin
                        r.stage = 0;
                    end
                end
            end
            default: begin
                if (!pmb && pa) r.mode = M_IDLE;
            end
        endcase
        return r;
    endfunction

    function automatic int exp_c(mdl_t s);
        int v = 0;
        if (s.mode == M_RUN)
            for (int i = 0; i < s.k; i++) v |= (1 << ((s.lead + i) % N_COMP));
        return v;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m <= mdl_reset();
        else        m <= mdl_step(m, PA, PB, PMB);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            check("model C", int'(C), exp_c(m));
            check("model Lead", int'(Lead), m.lead);
            check("model Fault", int'(Fault), (m.mode == M_LOCK) ? 1 : 0);
        end
    end

    // One clock: drive after the falling edge, return shortly after the rising edge.
    task automatic cyc(input bit pa, input bit pb, input bit pmb);
        @(negedge Clk);
        #1;
        PA = pa; PB = pb; PMB = pmb;
        @(posedge Clk);
        #2;
    endtask

    task automatic press_pa(input bit pb);
        repeat (PA_HOLD) cyc(1'b1, pb, 1'b0);
    endtask

    initial begin
        Reset = 1'b0; PA = 1'b0; PB = 1'b0; PMB = 1'b0;
        #3;
        check("reset C", int'(C), 0);
        check("reset Lead", int'(Lead), 0);
        check("reset Fault", int'(Fault), 0);
        #14 Reset = 1'b1;
        chk_en = 1'b1;

        // Lead alternation with wrap-around.
        cyc(0, 1, 0); check("pb1 C", int'(C), 3'b001); check("pb1 Lead", int'(Lead), 0);
        press_pa(0);  check("pa1 C", int'(C), 3'b000); check("pa1 Lead", int'(Lead), 1);
        cyc(0, 1, 0); check("pb2 C", int'(C), 3'b010);
        press_pa(0);  check("pa2 Lead", int'(Lead), 2);
        cyc(0, 1, 0); check("pb3 C", int'(C), 3'b100);

        // Staging from lead 2: 100 -> 101 after 8 cycles -> 111 after 16.
        repeat (7) cyc(0, 1, 0);
        check("stage7 C", int'(C), 3'b100);
        cyc(0, 1, 0); check("stage8 C", int'(C), 3'b101);
        repeat (7) cyc(0, 1, 0);
        check("stage15 C", int'(C), 3'b101);
        cyc(0, 1, 0); check("stage16 C", int'(C), 3'b111);
        repeat (10) cyc(0, 1, 0);
        check("full C", int'(C), 3'b111);
        press_pa(0);  check("pa3 C", int'(C), 3'b000); check("pa3 Lead wrap", int'(Lead), 0);

        // Lockout from RUN with C=011.
        cyc(0, 1, 0);
        repeat (8) cyc(0, 1, 0);
        check("pre-lock C", int'(C), 3'b011);
        cyc(0, 0, 1); check("lock C", int'(C), 0); check("lock Fault", int'(Fault), 1);
        cyc(0, 1, 0); check("lock pb Fault", int'(Fault), 1); check("lock pb C", int'(C), 0);
        cyc(1, 0, 1); check("lock pa+pmb Fault", int'(Fault), 1);
        cyc(1, 0, 0); check("unlock Fault", int'(Fault), 0); check("unlock Lead", int'(Lead), 0);

        // Priorities.
        cyc(1, 1, 1); check("all-high idle Fault", int'(Fault), 1);
        cyc(1, 0, 0);
        cyc(1, 0, 0); check("pa idle C", int'(C), 0);
        cyc(0, 1, 0); check("pb C", int'(C), 3'b001);
        press_pa(1);  check("pa+pb C", int'(C), 0); check("pa+pb Lead", int'(Lead), 1);

        // Asynchronous reset mid-RUN with C=110, Lead=1.
        cyc(0, 1, 0);
        repeat (8) cyc(0, 1, 0);
        check("pre-reset C", int'(C), 3'b110);
        check("pre-reset Lead", int'(Lead), 1);
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("async reset C", int'(C), 0);
        check("async reset Lead", int'(Lead), 0);
        #1 Reset = 1'b1;
        PB = 1'b0;

`ifdef ALT_COMPR_MINRUN_EN
        // Minimum run time before PA is honoured.
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0); check("minrun c2 C", int'(C), 3'b001);
        cyc(1, 0, 0); check("minrun c3 C", int'(C), 3'b001);
        cyc(1, 0, 0); check("minrun c4 C", int'(C), 0); check("minrun c4 Lead", int'(Lead), 1);
        cyc(0, 1, 0);
        cyc(0, 0, 1); check("minrun pmb Fault", int'(Fault), 1);
        cyc(1, 0, 0);
`endif

        // Randomized phase with occasional mid-cycle resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            #1;
            PB  = ($urandom_range(0, 1) == 0);
            PA  = ($urandom_range(0, 9) == 0);
            PMB = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 Reset = 1'b0;
                #2 Reset = 1'b1;
            end
        end
        @(negedge Clk);
        #1;
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alt_compr_n.md
ALT_COMPR_N -- requirements
Module: alt_compr_n

Interface
REQ-001 The block SHALL have parameter N_COMP, default 3, meaning number of compressors driven (legal 2..8).
REQ-002 The block SHALL have parameter STAGE_DLY, default 8, meaning consecutive PB-high cycles in RUN before one more compressor is staged on (legal 1..255).
REQ-003 The block SHALL have parameter MIN_RUN, default 4, meaning minimum RUN cycles before PA is honoured (used only with ALT_COMPR_MINRUN_EN; legal 1..255).
REQ-004 Clk  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 PA  input  1  high-pressure switch: stop all running compressors.
REQ-007 PB  input  1  low-pressure switch: demand, start or stage compressors.
REQ-008 PMB  input  1  maximum-pressure safety switch: force lockout.
REQ-009 C  output  N_COMP  compressor run commands, bit i drives compressor i.
REQ-010 Lead  output  clog2(N_COMP)  index of the current lead compressor.
REQ-011 Fault  output  1  high while in LOCKOUT.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, LOCKOUT; inputs are sampled on the rising Clk edge, and C, Lead and Fault are registered, so they change one cycle after the sampling edge.
REQ-013 Input priority SHALL be PMB > PA > PB whenever more than one is high.
REQ-014 IDLE: C=0; PB=1 and PMB=0 -> RUN with active count K=1.
REQ-015 RUN: C SHALL have exactly K bits set, at indices Lead, Lead+1, ..., Lead+K-1, each taken mod N_COMP (wrap-around past bit N_COMP-1 to bit 0).
REQ-016 RUN: while PB=1 and K<N_COMP, the stage counter SHALL increment each cycle; when it reaches STAGE_DLY, K increments by 1 and the counter clears; PB=0 clears the counter; at K=N_COMP the counter holds at 0.
REQ-017 RUN with PA=1 (and PMB=0) -> IDLE: C=0, K=0, and Lead <= (Lead+1) mod N_COMP, so the lead alternates every demand cycle.
REQ-018 PMB=1 in any state -> LOCKOUT: C=0, Fault=1, stage counter cleared, Lead unchanged.
REQ-019 LOCKOUT SHALL be left only on PA=1 and PMB=0, going to IDLE with Fault=0 and Lead unchanged; PB alone SHALL NOT exit LOCKOUT.
REQ-020 PA=1 in IDLE SHALL be a no-op; PB=1 in RUN at K=N_COMP SHALL be a no-op.

Reset
REQ-021 Reset=0 SHALL immediately force IDLE, C=0, Lead=0, Fault=0, K=0 and all counters to 0, independent of Clk.
REQ-022 Reset asserted mid-RUN or mid-LOCKOUT SHALL discard all history; Lead restarts at compressor 0.
REQ-023 After Reset deassertion, the first state change SHALL occur no earlier than the next rising Clk edge.

Configuration
REQ-024 Macro ALT_COMPR_MINRUN_EN defined: a run counter SHALL clear on entry to RUN and saturate at MIN_RUN; PA in RUN is ignored while the counter is below MIN_RUN; PMB is never masked.
REQ-025 Macro ALT_COMPR_MINRUN_EN undefined: PA SHALL be honoured on the first RUN cycle, and no run-counter logic SHALL be present.

Structure
REQ-026 A shared package alt_compr_pkg SHALL hold the state enum (IDLE, RUN, LOCKOUT), the counter width constant (8), and the rotate-mask function that builds C from Lead, K and N_COMP.
REQ-027 A single sub-module alt_compr_timer (8-bit clear/enable/saturating counter with terminal-count flag) SHALL be instantiated for the stage counter and, when enabled, for the run counter.

Verification
REQ-028 N_COMP=3, STAGE_DLY=8: reset, then PB pulse 1 cycle -> C=001, Lead=0; PA pulse -> C=000, Lead=1; PB pulse -> C=010; PA -> Lead=2; PB -> C=100; PA -> Lead=0 (wrap).
REQ-029 N_COMP=3, Lead=2: hold PB 16 cycles in RUN -> C goes 100, then 101 after 8 cycles, then 111 after 16 cycles; further PB leaves C=111.
REQ-030 PMB=1 during RUN with C=011 -> next cycle C=000, Fault=1; PB=1 -> no change; PA=1 with PMB=1 -> stays LOCKOUT; PA=1 with PMB=0 -> IDLE, Fault=0, Lead unchanged.
REQ-031 PA, PB and PMB all high in IDLE -> LOCKOUT; PA and PB high together in RUN -> IDLE with Lead advanced.
REQ-032 Reset=0 asserted between Clk edges mid-RUN with C=110, Lead=1 -> C=000 and Lead=0 immediately, before the next edge.
REQ-033 With ALT_COMPR_MINRUN_EN and MIN_RUN=4: PA asserted on RUN cycle 2 -> ignored; PA held through cycle 4 -> IDLE; PMB on RUN cycle 1 -> LOCKOUT at once.
